// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner: FSM states, default
// vector count and the reference SoP table for the team's example function.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int DEF_N_IN = 4;
   localparam int N_VEC    = 2**DEF_N_IN;

   // s = ~x&y&~w | x&y&z | ~y&w, bit k is the output for vector k = {x,y,w,z}
   localparam logic [N_VEC-1:0] SOP_REF_TABLE = 16'hAC3C;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle down-counter: load sets it to SETTLE, en counts it down to 1, and
// expire flags the last settle cycle so the FSM can move on to sampling.
module scan_settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(SETTLE);
      end else if (en && (cnt != CW'(1))) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expire = (cnt == CW'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input vectors of a boolean function block, assembles its truth
// table and compares it to an expected table. Optional macro SCAN_XCHECK_EN
// enables simulation-only detection of unknown values on s_in.
module truth_table_scanner
   import scan_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   output logic [N_IN-1:0]      vars,
   input  logic                 s_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        ones,
   output logic                 match,
   output logic [N_IN-1:0]      err_idx,
   output logic                 xflag
);

   localparam int NV = 2**N_IN;

   state_e          state;
   state_e          state_nx;
   logic [NV-1:0]   exp_q;
   logic            mismatch_q;

   logic            accept;
   logic            sample;
   logic            last_vec;
   logic            timer_load;
   logic            timer_en;
   logic            timer_expire;

   logic            s_unknown;
   logic            s_bit;
   logic            s_bad;

`ifdef SCAN_XCHECK_EN
   assign s_unknown = (s_in !== 1'b0) && (s_in !== 1'b1);
`else
   assign s_unknown = 1'b0;
`endif

   assign s_bit    = s_unknown ? 1'b0 : s_in;
   assign s_bad    = s_unknown || (s_bit != exp_q[vars]);
   assign last_vec = &vars;

   scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .en     (timer_en),
      .expire (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: defaulting every combinational output first keeps all paths
   // assigned, so no latch is inferred.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start)        state_nx = WAIT;
         WAIT:    if (timer_expire) state_nx = SAMPLE;
         SAMPLE:  state_nx = last_vec ? DONE : WAIT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      accept     = (state == IDLE) && start;
      sample     = (state == SAMPLE);
      timer_load = accept || (sample && !last_vec);
      timer_en   = (state == WAIT);
   end

   // Result registers; vars only moves on acceptance or a SAMPLE->WAIT step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_q      <= '0;
         mismatch_q <= 1'b0;
         vars       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         table_out  <= '0;
         ones       <= '0;
         match      <= 1'b0;
         err_idx    <= '0;
         xflag      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            exp_q      <= expected;
            mismatch_q <= 1'b0;
            vars       <= '0;
            busy       <= 1'b1;
            table_out  <= '0;
            ones       <= '0;
            match      <= 1'b0;
            err_idx    <= '0;
            xflag      <= 1'b0;
         end
         if (sample) begin
            table_out[vars] <= s_bit;
            ones            <= ones + {{N_IN{1'b0}}, s_bit};
            if (s_unknown) xflag <= 1'b1;
            if (s_bad && !mismatch_q) begin
               err_idx    <= vars;
               mismatch_q <= 1'b1;
            end
            if (last_vec) begin
               done  <= 1'b1;
               busy  <= 1'b0;
               match <= !(mismatch_q || s_bad);
            end else begin
               vars <= N_IN'(vars + 1'b1);
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: directed and random scans with a
// table-level reference model; the x-injection case needs SCAN_XCHECK_EN.
module tb_truth_table_scanner;
   import scan_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start_a = 1'b0;
   logic [15:0] exp_a = '0;
   logic [3:0]  vars_a;
   logic        s_a;
   logic        busy_a, done_a, match_a, xflag_a;
   logic [15:0] table_a;
   logic [4:0]  ones_a;
   logic [3:0]  err_a;
   logic [15:0] fn_a = '0;
   int          xvec_a = -1;

   logic        start_b = 1'b0;
   logic [15:0] exp_b = '0;
   logic [3:0]  vars_b;
   logic        s_b;
   logic        busy_b, done_b, match_b, xflag_b;
   logic [15:0] table_b;
   logic [4:0]  ones_b;
   logic [3:0]  err_b;
   logic [15:0] fn_b = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

`ifdef SCAN_XCHECK_EN
   assign s_a = (xvec_a >= 0 && int'(vars_a) == xvec_a) ? 1'bx : fn_a[vars_a];
`else
   assign s_a = fn_a[vars_a];
`endif
   assign s_b = fn_b[vars_b];

   truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
      .vars(vars_a), .s_in(s_a), .busy(busy_a), .done(done_a),
      .table_out(table_a), .ones(ones_a), .match(match_a),
      .err_idx(err_a), .xflag(xflag_a)
   );

   truth_table_scanner #(.N_IN(4), .SETTLE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
      .vars(vars_b), .s_in(s_b), .busy(busy_b), .done(done_b),
      .table_out(table_b), .ones(ones_b), .match(match_b),
      .err_idx(err_b), .xflag(xflag_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference function built straight from the boolean equation
   function automatic logic [15:0] sop_table();
      logic [15:0] t;
      logic [3:0]  v;
      for (int k = 0; k < 16; k++) begin
         v = 4'(k);
         t[k] = (!v[3] && v[2] && !v[1]) || (v[3] && v[2] && v[0]) || (!v[2] && v[1]);
      end
      return t;
   endfunction

   function automatic int lowest_set(input logic [15:0] d);
      for (int i = 0; i < 16; i++) if (d[i]) return i;
      return 0;
   endfunction

   // SETTLE=1 scan: start on edge 0, optional re-pulses at edges 5, 20, 33
   task automatic scan_a(input string tag, input logic [15:0] fn, input logic [15:0] exp,
                         input bit repulse, input int xvec);
      int          done_cnt, done_edge, vars_err, busy_err;
      logic [15:0] eff, diff;
      eff  = fn;
      diff = '0;
      if (xvec >= 0) eff[xvec] = 1'b0;
      diff = eff ^ exp;
      if (xvec >= 0) diff[xvec] = 1'b1;
      fn_a = fn; exp_a = exp; xvec_a = xvec;
      done_cnt = 0; done_edge = -1; vars_err = 0; busy_err = 0;
      for (int e = 0; e <= 40; e++) begin
         @(negedge clk);
         start_a = (e == 0) || (repulse && (e == 5 || e == 20 || e == 33));
         @(posedge clk);
         #1;
         if (e == 0) exp_a = ~exp;
         if (done_a) begin done_cnt++; done_edge = e; end
         if (int'(vars_a) != ((e / 2 > 15) ? 15 : e / 2)) vars_err++;
         if (busy_a !== (e < 32)) busy_err++;
      end
      start_a = 1'b0;
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_edge"}, done_edge, 32);
      check({tag, "_vars_seq_err"}, vars_err, 0);
      check({tag, "_busy_err"}, busy_err, 0);
      check({tag, "_table"}, table_a, eff);
      check({tag, "_ones"}, ones_a, $countones(eff));
      check({tag, "_match"}, match_a, diff == 16'h0);
      check({tag, "_err_idx"}, err_a, lowest_set(diff));
      check({tag, "_xflag"}, xflag_a, xvec >= 0);
   endtask

   // SETTLE=3 scan: done expected in the cycle after edge 64
   task automatic scan_b(input string tag, input logic [15:0] fn, input logic [15:0] exp);
      int done_edge;
      fn_b = fn; exp_b = exp; done_edge = -1;
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      for (int e = 1; e <= 100 && done_edge < 0; e++) begin
         @(posedge clk); #1;
         if (done_b) done_edge = e;
      end
      check({tag, "_done_edge"}, done_edge, 64);
      check({tag, "_table"}, table_b, fn);
      check({tag, "_ones"}, ones_b, $countones(fn));
      check({tag, "_match"}, match_b, fn == exp);
      check({tag, "_err_idx"}, err_b, lowest_set(fn ^ exp));
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic [15:0] sop, fn, exp;
      int          done_cnt;
      sop = sop_table();

      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("reset_vars", vars_a, 0);
      check("reset_flags", {busy_a, done_a, match_a, xflag_a}, 0);
      check("reset_results", {table_a, ones_a, err_a}, 0);
      check("sop_ref_const", sop, SOP_REF_TABLE);

      scan_a("sop_match", sop, 16'hAC3C, 1'b0, -1);
      scan_a("sop_miss0", sop, 16'hAC3D, 1'b0, -1);
      scan_a("sop_repulse", sop, 16'hAC3C, 1'b1, -1);

      scan_b("ones_all", 16'hFFFF, 16'hFFFF);
      fn = 16'($urandom);
      scan_b("b_rand", fn, fn ^ 16'h8000);

      // Reset asserted so that edge 10 of a running scan applies it
      fn_a = sop; exp_a = sop;
      for (int e = 0; e <= 10; e++) begin
         @(negedge clk);
         start_a = (e == 0);
         if (e == 10) rst_n = 1'b0;
         @(posedge clk);
      end
      start_a = 1'b0;
      #1;
      check("midrst_vars", vars_a, 0);
      check("midrst_flags", {busy_a, done_a, match_a, xflag_a}, 0);
      check("midrst_results", {table_a, ones_a, err_a}, 0);
      @(negedge clk); rst_n = 1'b1;
      done_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_a || busy_a) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      scan_a("after_rst", sop, 16'hAC3C, 1'b0, -1);

      for (int i = 0; i < 4; i++) begin
         fn = 16'($urandom);
         case (i % 3)
            0:       exp = fn;
            1:       exp = fn ^ (16'h1 << $urandom_range(15, 0));
            default: exp = 16'($urandom);
         endcase
         scan_a($sformatf("rand%0d", i), fn, exp, 1'b0, -1);
      end

`ifdef SCAN_XCHECK_EN
      scan_a("xinj", sop, 16'hAC3C, 1'b0, 6);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
